// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - shared privilege, CSR and trap-controller definitions
package trap_ctrl_pkg;

  // Privilege levels as encoded in mstatus.MPP / priv_mode
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // mtvec.MODE encodings
  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  // mcause value for a machine timer interrupt (interrupt bit set, code 7)
  localparam logic [31:0] CAUSE_M_TIMER_INT = 32'h8000_0007;

  // Trap sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_FLUSH    = 2'b01,
    ST_COMMIT   = 2'b10,
    ST_REDIRECT = 2'b11
  } trap_state_t;

  // Kind of event currently being serviced
  typedef enum logic [1:0] {
    EV_NONE = 2'b00,
    EV_EXC  = 2'b01,
    EV_INT  = 2'b10,
    EV_MRET = 2'b11
  } trap_event_t;

  // Trap base address: mtvec with the MODE field cleared
  function automatic logic [31:0] mtvec_base(input logic [31:0] mtvec);
    return {mtvec[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_ctrl_vec_calc.sv
// rtl/trap_ctrl_vec_calc.sv - trap target address calculation (TRAP_VECTORED_EN enables vectored mode)
module trap_vec_calc
  import trap_ctrl_pkg::*;
(
  input  logic [31:0] mtvec_i,
  input  logic [31:0] cause_i,
  input  logic        is_interrupt_i,
  output logic [31:0] target_o
);

  logic [31:0] base;

  assign base = mtvec_base(mtvec_i);

`ifdef TRAP_VECTORED_EN
  logic unused_cause_hi;
  assign unused_cause_hi = ^cause_i[31:30];

  // Vectored interrupts jump to base + 4*code; the add wraps modulo 2^32
  always_comb begin
    target_o = base;
    if (is_interrupt_i && (mtvec_i[1:0] == MTVEC_MODE_VECTORED)) begin
      target_o = base + {cause_i[29:0], 2'b00};
    end
  end
`else
  logic unused_vec_inputs;
  assign unused_vec_inputs = ^{cause_i, is_interrupt_i, mtvec_i[1:0]};

  // Direct mode only: every trap lands on the base address
  always_comb begin
    target_o = base;
  end
`endif

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap/mret sequencer: flush, CSR commit, fetch redirect (TRAP_VECTORED_EN selects vectored mtvec)
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [31:0] exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_val,
  input  logic        mret_req,
  input  logic [31:0] next_pc,
  input  logic        timer_interrupt,
  input  logic        mie_mtie,
  input  logic        mstatus_mie,
  input  logic [1:0]  priv_mode,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        flush_req,
  input  logic        flush_ack,
  output logic        trap_enter,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_val,
  output logic        mret_exec,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  trap_state_t state_q;
  trap_event_t event_q;
  logic [31:0] cause_q;
  logic [31:0] pc_q;
  logic [31:0] val_q;

  logic        flush_req_q;
  logic        trap_enter_q;
  logic [31:0] trap_cause_q;
  logic [31:0] trap_pc_q;
  logic [31:0] trap_val_q;
  logic        mret_exec_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;

  trap_event_t event_d;
  logic [31:0] cause_d;
  logic [31:0] pc_d;
  logic [31:0] val_d;
  logic [31:0] target_d;
  logic [31:0] vec_target;
  logic        int_take;

  // A timer interrupt is taken when enabled and either globally enabled or running in U-mode
  assign int_take = timer_interrupt & mie_mtie & (mstatus_mie | (priv_mode == PRIV_U));

  // Pick the single winning event in IDLE: exception, then mret, then interrupt
  always_comb begin
    event_d = EV_NONE;
    cause_d = 32'h0;
    pc_d    = 32'h0;
    val_d   = 32'h0;
    if (exc_valid) begin
      event_d = EV_EXC;
      cause_d = exc_cause;
      pc_d    = exc_pc;
      val_d   = exc_val;
    end else if (mret_req) begin
      event_d = EV_MRET;
    end else if (int_take) begin
      event_d = EV_INT;
      cause_d = CAUSE_M_TIMER_INT;
      pc_d    = next_pc;
    end
  end

  trap_vec_calc u_vec_calc (
    .mtvec_i        (mtvec_in),
    .cause_i        (cause_q),
    .is_interrupt_i (event_q == EV_INT),
    .target_o       (vec_target)
  );

  // mret returns to mepc; traps go through the vector calculation
  always_comb begin
    target_d = vec_target;
    if (event_q == EV_MRET) begin
      target_d = mepc_in;
    end
  end

  // Sequencer: latch event, hold flush until drained, commit one cycle, redirect one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      event_q          <= EV_NONE;
      cause_q          <= 32'h0;
      pc_q             <= 32'h0;
      val_q            <= 32'h0;
      flush_req_q      <= 1'b0;
      trap_enter_q     <= 1'b0;
      trap_cause_q     <= 32'h0;
      trap_pc_q        <= 32'h0;
      trap_val_q       <= 32'h0;
      mret_exec_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
    end else begin
      flush_req_q      <= 1'b0;
      trap_enter_q     <= 1'b0;
      trap_cause_q     <= 32'h0;
      trap_pc_q        <= 32'h0;
      trap_val_q       <= 32'h0;
      mret_exec_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
      case (state_q)
        ST_IDLE: begin
          if (event_d != EV_NONE) begin
            event_q     <= event_d;
            cause_q     <= cause_d;
            pc_q        <= pc_d;
            val_q       <= val_d;
            flush_req_q <= 1'b1;
            state_q     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (flush_ack) begin
            state_q <= ST_COMMIT;
            if (event_q == EV_MRET) begin
              mret_exec_q <= 1'b1;
            end else begin
              trap_enter_q <= 1'b1;
              trap_cause_q <= cause_q;
              trap_pc_q    <= pc_q;
              trap_val_q   <= val_q;
            end
          end else begin
            flush_req_q <= 1'b1;
          end
        end
        ST_COMMIT: begin
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= target_d;
          state_q          <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          event_q <= EV_NONE;
          cause_q <= 32'h0;
          pc_q    <= 32'h0;
          val_q   <= 32'h0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign flush_req      = flush_req_q;
  assign trap_enter     = trap_enter_q;
  assign trap_cause     = trap_cause_q;
  assign trap_pc        = trap_pc_q;
  assign trap_val       = trap_val_q;
  assign mret_exec      = mret_exec_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - self-checking bench for trap_ctrl (expected targets follow TRAP_VECTORED_EN)
module tb_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        exc_valid;
  logic [31:0] exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_val;
  logic        mret_req;
  logic [31:0] next_pc;
  logic        timer_interrupt;
  logic        mie_mtie;
  logic        mstatus_mie;
  logic [1:0]  priv_mode;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;
  logic        flush_req;
  logic        flush_ack;
  logic        trap_enter;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_val;
  logic        mret_exec;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  trap_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .exc_valid       (exc_valid),
    .exc_cause       (exc_cause),
    .exc_pc          (exc_pc),
    .exc_val         (exc_val),
    .mret_req        (mret_req),
    .next_pc         (next_pc),
    .timer_interrupt (timer_interrupt),
    .mie_mtie        (mie_mtie),
    .mstatus_mie     (mstatus_mie),
    .priv_mode       (priv_mode),
    .mtvec_in        (mtvec_in),
    .mepc_in         (mepc_in),
    .flush_req       (flush_req),
    .flush_ack       (flush_ack),
    .trap_enter      (trap_enter),
    .trap_cause      (trap_cause),
    .trap_pc         (trap_pc),
    .trap_val        (trap_val),
    .mret_exec       (mret_exec),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] TGT_TIMER_VEC  = 32'h8000_001C;
  localparam logic [31:0] TGT_TIMER_WRAP = 32'h0000_000C;
`else
  localparam logic [31:0] TGT_TIMER_VEC  = 32'h8000_0000;
  localparam logic [31:0] TGT_TIMER_WRAP = 32'hFFFF_FFF0;
`endif

  typedef struct {
    logic        exc;
    logic        mret;
    logic        timer;
    logic        mtie;
    logic        mie;
    logic [1:0]  priv;
    logic [31:0] cause;
    logic [31:0] pc;
    logic [31:0] val;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] npc;
    int          d;
    logic        reexc;
    logic        take;
    logic        is_mret;
    logic [31:0] e_cause;
    logic [31:0] e_pc;
    logic [31:0] e_val;
    logic [31:0] e_tgt;
  } vec_t;

  typedef struct {
    logic        is_mret;
    logic [31:0] cause;
    logic [31:0] pc;
    logic [31:0] val;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic cur_valid;
  vec_t vt[$];
  int   total;
  int   bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v.exc = 0; v.mret = 0; v.timer = 0; v.mtie = 0; v.mie = 0; v.priv = 2'b11;
    v.cause = 0; v.pc = 0; v.val = 0; v.mtvec = 0; v.mepc = 0; v.npc = 0;
    v.d = 1; v.reexc = 0; v.take = 0; v.is_mret = 0;
    v.e_cause = 0; v.e_pc = 0; v.e_val = 0; v.e_tgt = 0;
    return v;
  endfunction

  function automatic vec_t mk_exc(input logic [31:0] c, input logic [31:0] p, input logic [31:0] x,
                                  input logic [31:0] tv, input int d, input logic [31:0] tgt);
    vec_t v = blank();
    v.exc = 1; v.cause = c; v.pc = p; v.val = x; v.mtvec = tv; v.d = d;
    v.take = 1; v.e_cause = c; v.e_pc = p; v.e_val = x; v.e_tgt = tgt;
    return v;
  endfunction

  function automatic vec_t mk_int(input logic [31:0] tv, input logic [31:0] np, input logic [1:0] pr,
                                  input logic te, input logic me, input int d, input logic tk,
                                  input logic [31:0] tgt);
    vec_t v = blank();
    v.timer = 1; v.mtvec = tv; v.npc = np; v.priv = pr; v.mtie = te; v.mie = me; v.d = d;
    v.take = tk; v.e_cause = 32'h8000_0007; v.e_pc = np; v.e_val = 0; v.e_tgt = tgt;
    return v;
  endfunction

  function automatic vec_t mk_mret(input logic [31:0] ep, input logic [31:0] tv, input int d);
    vec_t v = blank();
    v.mret = 1; v.mepc = ep; v.mtvec = tv; v.d = d;
    v.take = 1; v.is_mret = 1; v.e_tgt = ep;
    return v;
  endfunction

  // Scoreboard: pop on each commit pulse, check redirect target on the following redirect
  always @(negedge clk) begin
    if (!rst) begin
      chk("commit_exclusive", {31'b0, trap_enter & mret_exec}, 32'h0);
      if (!trap_enter) chk("trap_fields_zero", trap_cause | trap_pc | trap_val, 32'h0);
      if (!redirect_valid) chk("redirect_pc_zero", redirect_pc, 32'h0);
      if (trap_enter || mret_exec) begin
        chk("commit_expected", {31'b0, sb.size() != 0}, 32'h1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          cur_valid = 1'b1;
          chk("commit_kind_mret", {31'b0, mret_exec}, {31'b0, cur.is_mret});
          if (!cur.is_mret) begin
            chk("trap_cause", trap_cause, cur.cause);
            chk("trap_pc", trap_pc, cur.pc);
            chk("trap_val", trap_val, cur.val);
          end
        end
      end
      if (redirect_valid) begin
        chk("redirect_after_commit", {31'b0, cur_valid}, 32'h1);
        if (cur_valid) chk("redirect_pc", redirect_pc, cur.tgt);
        cur_valid = 1'b0;
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    mtvec_in = v.mtvec; mepc_in = v.mepc; next_pc = v.npc; priv_mode = v.priv;
    mie_mtie = v.mtie; mstatus_mie = v.mie; timer_interrupt = v.timer;
    exc_valid = v.exc; exc_cause = v.cause; exc_pc = v.pc; exc_val = v.val;
    mret_req = v.mret;
    if (v.take) sb.push_back('{v.is_mret, v.e_cause, v.e_pc, v.e_val, v.e_tgt});
    if (!v.take) begin
      exc_valid = 0; mret_req = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        chk($sformatf("v%0d_no_flush", idx), {30'b0, flush_req, busy}, 32'h0);
      end
      timer_interrupt = 0;
    end else begin
      for (int k = 1; k <= v.d; k++) begin
        @(negedge clk);
        if (k == 1) begin
          mret_req = 0; timer_interrupt = 0;
          exc_valid = v.reexc; exc_cause = 32'hF; exc_pc = 32'h0BAD_0000; exc_val = 32'h1;
        end else begin
          exc_valid = 0;
        end
        chk($sformatf("v%0d_flush_req_%0d", idx, k), {31'b0, flush_req}, 32'h1);
        if (k == v.d) flush_ack = 1;
      end
      @(negedge clk);
      flush_ack = 0; exc_valid = 0;
      chk($sformatf("v%0d_commit_pulse", idx), {30'b0, trap_enter | mret_exec, flush_req}, 32'h2);
      @(negedge clk);
      chk($sformatf("v%0d_redirect", idx), {30'b0, redirect_valid, trap_enter | mret_exec}, 32'h2);
      @(negedge clk);
      chk($sformatf("v%0d_back_idle", idx), {30'b0, redirect_valid, busy}, 32'h0);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vec_t v;
    total = 0; bad = 0; cur_valid = 1'b0;
    rst = 1; exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_val = 0; mret_req = 0;
    next_pc = 0; timer_interrupt = 0; mie_mtie = 0; mstatus_mie = 0; priv_mode = 2'b11;
    mtvec_in = 0; mepc_in = 0; flush_ack = 0;

    vt.push_back(mk_exc(32'h2, 32'h100, 32'hDEAD_BEEF, 32'h8000_0000, 3, 32'h8000_0000));
    vt.push_back(mk_int(32'h8000_0001, 32'h240, 2'b11, 1, 1, 1, 1, TGT_TIMER_VEC));
    vt.push_back(mk_int(32'h8000_0001, 32'h240, 2'b11, 1, 0, 1, 0, 32'h0));
    vt.push_back(mk_int(32'h0000_1000, 32'h300, 2'b00, 1, 0, 2, 1, 32'h0000_1000));
    vt.push_back(mk_mret(32'h200, 32'h8000_0000, 1));
    v = mk_exc(32'h5, 32'h44, 32'h11, 32'h0000_2001, 2, 32'h0000_2000);
    v.mret = 1; v.timer = 1; v.mtie = 1; v.mie = 1; v.npc = 32'h999; v.reexc = 1;
    vt.push_back(v);
    vt.push_back(mk_int(32'h8000_0001, 32'h240, 2'b11, 0, 1, 1, 0, 32'h0));
    vt.push_back(mk_int(32'hFFFF_FFF1, 32'h1234, 2'b11, 1, 1, 4, 1, TGT_TIMER_WRAP));
    vt.push_back(mk_exc(32'hB, 32'hFFFF_FFFC, 32'h0, 32'h1234_5673, 1, 32'h1234_5670));

    repeat (2) @(negedge clk);
    chk("reset_outputs", {27'b0, flush_req, trap_enter, mret_exec, redirect_valid, busy}, 32'h0);
    chk("reset_buses", trap_cause | trap_pc | trap_val | redirect_pc, 32'h0);
    rst = 0;

    flush_ack = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_ack_ignored", {30'b0, busy, flush_req}, 32'h0);
    end
    flush_ack = 0;

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

    @(negedge clk);
    exc_valid = 1; exc_cause = 32'h7; exc_pc = 32'h500; exc_val = 32'h9; mtvec_in = 32'h4000;
    @(negedge clk);
    exc_valid = 0;
    chk("rst_pre_flush", {31'b0, flush_req}, 32'h1);
    #2 rst = 1;
    #1;
    chk("rst_async_outputs", {27'b0, flush_req, trap_enter, mret_exec, redirect_valid, busy}, 32'h0);
    chk("rst_async_buses", trap_cause | trap_pc | trap_val | redirect_pc, 32'h0);
    @(negedge clk);
    rst = 0;
    flush_ack = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 3) flush_ack = 0;
      chk("rst_no_resume", {28'b0, flush_req, trap_enter, redirect_valid, busy}, 32'h0);
    end

    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have exc_valid  in  1  precise synchronous exception from commit stage; exc_cause  in  32  cause code; exc_pc  in  32  faulting PC; exc_val  in  32  mtval value.
REQ-003 SHALL have mret_req  in  1  mret reached commit; next_pc  in  32  PC of next unretired instruction, used as mepc for interrupts.
REQ-004 SHALL have timer_interrupt, mie_mtie, mstatus_mie  in  1 each; priv_mode  in  2; mtvec_in  in  32; mepc_in  in  32, all from the CSR file.
REQ-005 SHALL have flush_req  out  1  pipeline flush request; flush_ack  in  1  pipeline drained.
REQ-006 SHALL have trap_enter  out  1; trap_cause, trap_pc, trap_val  out  32 each; mret_exec  out  1, all to the CSR file.
REQ-007 SHALL have redirect_valid  out  1; redirect_pc  out  32  fetch redirect; busy  out  1  high while state != IDLE.

Function
REQ-008 SHALL implement FSM states IDLE, FLUSH, COMMIT, REDIRECT, held in a registered state variable.
REQ-009 In IDLE, event priority SHALL be exception > mret > interrupt; only the winning event is latched, others dropped.
REQ-010 Interrupt taken SHALL require timer_interrupt & mie_mtie & (mstatus_mie | priv_mode==PRIV_U); latched cause 0x8000_0007, pc = next_pc, val = 0.
REQ-011 Exception SHALL latch exc_cause, exc_pc, exc_val; mret SHALL latch only the event kind.
REQ-012 IDLE with any event SHALL move to FLUSH next cycle; flush_req SHALL be high in every FLUSH cycle.
REQ-013 FLUSH SHALL stay until flush_ack=1 is sampled, then move to COMMIT; flush_ack outside FLUSH SHALL be ignored.
REQ-014 COMMIT SHALL last exactly one cycle: trap_enter=1 with latched cause/pc/val for trap events, or mret_exec=1 for mret; never both.
REQ-015 Target SHALL be latched in COMMIT: trap -> {mtvec_in[31:2],2'b00} (+ vector offset per REQ-022); mret -> mepc_in.
REQ-016 REDIRECT SHALL last exactly one cycle with redirect_valid=1 and redirect_pc=latched target, then return to IDLE.
REQ-017 exc_valid, mret_req, interrupts while busy SHALL be ignored (pipeline is being flushed); minimum event-to-redirect latency 3 cycles (flush_ack same cycle as FLUSH entry).
REQ-018 trap_cause/pc/val SHALL be 0 when trap_enter=0; redirect_pc SHALL be 0 when redirect_valid=0.
REQ-019 Target arithmetic SHALL be 32-bit modulo 2^32 (wrap-around, no overflow flag).

Reset
REQ-020 rst SHALL force state IDLE, all latched registers 0, all outputs 0, including mid-FLUSH or mid-COMMIT; no pulse SHALL be emitted after reset deasserts without a new event.

Configuration
REQ-021 Macro TRAP_VECTORED_EN SHALL select vectored-mode support.
REQ-022 With TRAP_VECTORED_EN defined: mtvec_in[1:0]==2'b01 and interrupt -> target = base + 4*cause[30:0]; exceptions always use base.
REQ-023 Without TRAP_VECTORED_EN: mtvec_in[1:0] ignored, every trap targets base.

Structure
REQ-024 State enum (trap_state_t) and interrupt cause constant (CAUSE_M_TIMER_INT = 0x8000_0007) SHALL live in the shared defines package beside the existing PRIV_* and CSR constants.
REQ-025 A single combinational sub-module trap_vec_calc (mtvec, cause, is_interrupt -> target) SHALL hold REQ-015/022/023 logic; all sequencing stays in trap_ctrl.

Verification
REQ-026 exc_valid, cause 2, pc 0x100, val 0xDEADBEEF, mtvec 0x8000_0000, flush_ack after 3 cycles -> flush_req 3 cycles, trap_enter one pulse (2/0x100/0xDEADBEEF), next cycle redirect_pc 0x8000_0000.
REQ-027 TRAP_VECTORED_EN, mtvec 0x8000_0001, timer pending, mtie=1, mstatus_mie=1, next_pc 0x240 -> trap_cause 0x8000_0007, trap_pc 0x240, trap_val 0, redirect_pc 0x8000_001C; same stimulus without macro -> 0x8000_0000.
REQ-028 Timer pending, mtie=1, mstatus_mie=0: priv M -> no flush_req for 20 cycles; priv U -> trap taken.
REQ-029 mret_req, mepc_in 0x200 -> mret_exec one pulse, trap_enter never high, redirect_pc 0x200.
REQ-030 exc_valid + mret_req + interrupt same cycle -> only exception serviced; new exc_valid during FLUSH -> ignored, single trap_enter.
REQ-031 rst asserted while in FLUSH -> all outputs 0 immediately, no trap_enter or redirect_valid after release.
